// File: rtl/uart_rx_cfg_if.sv
// Bus of uart_rx_cfg: serial line and acknowledge in, received frame and status flags out.
interface uart_rx_cfg_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 RX;
  logic                 clr_rdy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rdy;
  logic                 frm_err;
  logic                 par_err;
  logic                 ovr_err;

  modport master (
    output RX, clr_rdy,
    input  rx_data, rdy, frm_err, par_err, ovr_err
  );

  modport slave (
    input  RX, clr_rdy,
    output rx_data, rdy, frm_err, par_err, ovr_err
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// UART receiver with mid-bit sampling, framing/overrun flags and a consumer acknowledge.
// Optional parity stage and checker are built when UART_RX_PARITY_EN is defined.
module uart_rx_cfg #(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_ODD = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_cfg_if.slave bus
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned BIT_W = 4;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [2:0]           sync;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad;
  logic                 rx_s;
  logic                 fall;

  // sync[1] is the settled line level, sync[2] its previous value
  assign rx_s = sync[1];
  assign fall = ~sync[1] & sync[2];

`ifndef UART_RX_PARITY_EN
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign par_bad           = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync        <= 3'b111;
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      bus.rx_data <= '0;
      bus.rdy     <= 1'b0;
      bus.frm_err <= 1'b0;
      bus.par_err <= 1'b0;
      bus.ovr_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
`endif
    end else begin
      sync <= {sync[1:0], bus.RX};

      if (bus.clr_rdy) begin
        bus.rdy     <= 1'b0;
        bus.frm_err <= 1'b0;
        bus.par_err <= 1'b0;
        bus.ovr_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
          end
        end

        // confirm the start bit half a bit later; a high line here was a glitch
        START: begin
          if (cnt == HALF_CNT) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == LAST_CNT) begin
            cnt     <= '0;
            par_bad <= rx_s ^ (^shift) ^ PARITY_ODD;
            state   <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif

        // deliver on an empty slot or a same-cycle acknowledge, otherwise flag overrun
        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            state <= IDLE;
            if (!bus.rdy || bus.clr_rdy) begin
              bus.rx_data <= shift;
              bus.rdy     <= 1'b1;
              bus.frm_err <= ~rx_s;
              bus.par_err <= par_bad;
              bus.ovr_err <= 1'b0;
            end else begin
              bus.ovr_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Randomized and directed frames against a cycle-window model of the receiver outputs.
module tb_uart_rx_cfg;

  localparam int unsigned BAUD_DIV   = 64;
  localparam int unsigned DATA_BITS  = 8;
  localparam bit          PARITY_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif
  // rdy must rise within [WIN_LO, WIN_HI] cycles of the line falling edge
  localparam int WIN_LO = int'((2 * DATA_BITS + 3) * BAUD_DIV / 2 + PAR_BITS * BAUD_DIV);
  localparam int WIN_HI = WIN_LO + 5;
  // 200 clocks at the default divisor, scaled to this divisor
  localparam int GLITCH = int'(200 * BAUD_DIV / 868);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_cfg_if #(.DATA_BITS(DATA_BITS)) bus ();

  uart_rx_cfg #(
    .BAUD_DIV  (BAUD_DIV),
    .DATA_BITS (DATA_BITS),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // expected visible state
  logic [DATA_BITS-1:0] m_data = '0;
  logic m_rdy = 1'b0, m_frm = 1'b0, m_par = 1'b0, m_ovr = 1'b0;

  // frame in flight
  bit                   f_valid = 1'b0;
  int                   f_t0    = 0;
  logic [DATA_BITS-1:0] f_data  = '0;
  bit                   f_frm   = 1'b0;
  bit                   f_perr  = 1'b0;
  bit                   f_clr   = 1'b0;

  int   rise_off = -1;
  logic prev_rdy = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // per-cycle comparison against the model, skipping only the stop-sample window
  initial begin : compare
    logic [DATA_BITS+3:0] got;
    logic [DATA_BITS+3:0] exp;
    bit in_win;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      in_win = 1'b0;
      if (!rst_n) begin
        m_data = '0; m_rdy = 1'b0; m_frm = 1'b0; m_par = 1'b0; m_ovr = 1'b0;
        f_valid = 1'b0;
      end else begin
        in_win = f_valid && (cyc - f_t0 >= WIN_LO) && (cyc - f_t0 <= WIN_HI);
        if (in_win) begin
          if (bus.rdy && !prev_rdy) rise_off = cyc - f_t0;
        end else begin
          if (f_valid && (cyc - f_t0 > WIN_HI)) begin
            if (f_clr || !m_rdy) begin
              m_data = f_data; m_rdy = 1'b1; m_frm = f_frm; m_par = f_perr; m_ovr = 1'b0;
            end else begin
              m_ovr = 1'b1;
            end
            f_valid = 1'b0;
          end
          if (bus.clr_rdy) begin
            m_rdy = 1'b0; m_frm = 1'b0; m_par = 1'b0; m_ovr = 1'b0;
          end
        end
      end
      if (!in_win) begin
        got = {bus.rdy, bus.frm_err, bus.par_err, bus.ovr_err, bus.rx_data};
        exp = {m_rdy, m_frm, m_par, m_ovr, m_data};
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL cycle_check cyc=%0d got rdy/frm/par/ovr=%b%b%b%b data=0x%0h want %b%b%b%b data=0x%0h",
                   cyc, bus.rdy, bus.frm_err, bus.par_err, bus.ovr_err, bus.rx_data,
                   m_rdy, m_frm, m_par, m_ovr, m_data);
        end
      end
      prev_rdy = bus.rdy;
    end
  end

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr_rdy = 1'b1;
    @(negedge clk);
    bus.clr_rdy = 1'b0;
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BAUD_DIV) @(negedge clk);
  endtask

  // clr_off >= 0 pulses clr_rdy so that it is seen on edge f_t0 + clr_off;
  // coinc tells the model that pulse lands on the stop-sample edge
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit stop_bit, input bit par_ok,
                            input int clr_off, input bit coinc, input bit hold_low);
`ifdef UART_RX_PARITY_EN
    bit pbit;
    pbit = (^d) ^ PARITY_ODD ^ !par_ok;
`endif
    @(negedge clk);
    bus.RX  = 1'b0;
    f_t0    = cyc + 1;
    f_data  = d;
    f_frm   = !stop_bit;
    f_perr  = (PAR_BITS != 0) && !par_ok;
    f_clr   = coinc;
    f_valid = 1'b1;
    fork
      begin
        repeat (BAUD_DIV) @(negedge clk);
        for (int i = 0; i < int'(DATA_BITS); i++) begin
          bus.RX = d[i];
          repeat (BAUD_DIV) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        bus.RX = pbit;
        repeat (BAUD_DIV) @(negedge clk);
`endif
        bus.RX = stop_bit;
        repeat (BAUD_DIV) @(negedge clk);
        bus.RX = hold_low ? 1'b0 : 1'b1;
      end
      begin
        if (clr_off >= 0) begin
          while (cyc + 1 < f_t0 + clr_off) @(negedge clk);
          bus.clr_rdy = 1'b1;
          @(negedge clk);
          bus.clr_rdy = 1'b0;
        end
      end
    join
  endtask

  initial begin : stimulus
    logic [DATA_BITS-1:0] d;
    bit stop, pok;
    int coff;

    bus.RX      = 1'b1;
    bus.clr_rdy = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_rdy", int'(bus.rdy), 0);
    chk("reset_data", int'(bus.rx_data), 0);
    chk("reset_flags", int'({bus.frm_err, bus.par_err, bus.ovr_err}), 0);
    rst_n = 1'b1;
    idle_bits(1);

    // basic frame and rdy latency
    send_frame(8'hA5, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    @(negedge clk);
    chk("a5_data", int'(bus.rx_data), 'hA5);
    chk("a5_rdy", int'(bus.rdy), 1);
    chk("a5_flags", int'({bus.frm_err, bus.par_err, bus.ovr_err}), 0);
    chk("a5_latency_in_window", int'(rise_off >= WIN_LO && rise_off <= WIN_HI), 1);
    pulse_clr();

    // short low glitch is a false start
    @(negedge clk);
    bus.RX = 1'b0;
    repeat (GLITCH) @(negedge clk);
    bus.RX = 1'b1;
    idle_bits(2);
    chk("glitch_rdy", int'(bus.rdy), 0);
    send_frame(8'h3C, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    @(negedge clk);
    chk("3c_data", int'(bus.rx_data), 'h3C);
    pulse_clr();

    // framing error still delivers
    send_frame(8'h55, 1'b0, 1'b1, -1, 1'b0, 1'b0);
    @(negedge clk);
    chk("55_rdy", int'(bus.rdy), 1);
    chk("55_frm", int'(bus.frm_err), 1);
    chk("55_data", int'(bus.rx_data), 'h55);
    pulse_clr();
    @(negedge clk);
    chk("55_cleared", int'({bus.rdy, bus.frm_err, bus.par_err, bus.ovr_err}), 0);

    // overrun, then acknowledge coincident with the stop sample
    send_frame(8'h11, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovr_data", int'(bus.rx_data), 'h11);
    chk("ovr_flag", int'(bus.ovr_err), 1);
    pulse_clr();
    send_frame(8'h11, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, rise_off, 1'b1, 1'b0);
    @(negedge clk);
    chk("coinc_data", int'(bus.rx_data), 'h22);
    chk("coinc_ovr", int'(bus.ovr_err), 0);
    chk("coinc_rdy", int'(bus.rdy), 1);
    pulse_clr();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    @(negedge clk);
    chk("par_good", int'(bus.par_err), 0);
    pulse_clr();
    send_frame(8'h07, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    @(negedge clk);
    chk("par_bad", int'(bus.par_err), 1);
    pulse_clr();
`endif

    // held-low break gives exactly one frame
    send_frame(8'h00, 1'b0, 1'b1, -1, 1'b0, 1'b1);
    idle_bits(3 * int'(DATA_BITS));
    bus.RX = 1'b1;
    idle_bits(1);
    chk("break_rdy", int'(bus.rdy), 1);
    chk("break_frm", int'(bus.frm_err), 1);
    chk("break_ovr", int'(bus.ovr_err), 0);
    pulse_clr();

    // randomized traffic with acknowledges between and inside frames
    for (int k = 0; k < 40; k++) begin
      d    = DATA_BITS'($urandom);
      stop = ($urandom_range(7) != 0);
      pok  = ($urandom_range(3) != 0);
      coff = ($urandom_range(2) == 0) ? int'($urandom_range(WIN_LO - 2, BAUD_DIV)) : -1;
      send_frame(d, stop, pok, coff, 1'b0, 1'b0);
      if ($urandom_range(1) == 1) pulse_clr();
      repeat ($urandom_range(BAUD_DIV)) @(negedge clk);
    end
    pulse_clr();

    // reset in the middle of a frame abandons it
    send_frame(8'h1B, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    @(negedge clk);
    chk("1b_data", int'(bus.rx_data), 'h1B);
    pulse_clr();
    @(negedge clk);
    bus.RX = 1'b0;
    repeat (4 * BAUD_DIV) @(negedge clk);
    rst_n  = 1'b0;
    bus.RX = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset_data", int'(bus.rx_data), 0);
    rst_n = 1'b1;
    idle_bits(int'(DATA_BITS) + 3);
    chk("midreset_rdy", int'(bus.rdy), 0);
    send_frame(8'h2D, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    @(negedge clk);
    chk("2d_data", int'(bus.rx_data), 'h2D);
    chk("2d_rdy", int'(bus.rdy), 1);
    idle_bits(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter: BAUD_DIV, 868, clk cycles per bit period (legal range 16..4095).
REQ-003 Parameter: DATA_BITS, 8, data bits per frame (legal range 5..8).
REQ-004 Parameter: PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only with UART_RX_PARITY_EN).
REQ-005 Port: clk  input  1  system clock, rising edge.
REQ-006 Port: rst_n  input  1  asynchronous active-low reset.
REQ-007 Port: RX  input  1  asynchronous serial line, idle high.
REQ-008 Port: clr_rdy  input  1  one-cycle pulse; consumer acknowledges frame and error flags.
REQ-009 Port: rx_data  output  DATA_BITS  last accepted frame, LSB received first.
REQ-010 Port: rdy  output  1  frame available.
REQ-011 Port: frm_err  output  1  stop bit sampled low.
REQ-012 Port: par_err  output  1  parity mismatch; tied 0 without UART_RX_PARITY_EN.
REQ-013 Port: ovr_err  output  1  frame completed while rdy was still set.

Function
REQ-014 RX SHALL pass through two synchroniser flops; a third flop SHALL detect the falling edge (synced low, previous high).
REQ-015 States SHALL be IDLE, START, DATA, PARITY (macro only) and STOP; IDLE is the reset state.
REQ-016 IDLE -> START on a detected falling edge; the baud counter clears to 0.
REQ-017 In START, at count BAUD_DIV/2 (integer division), synced RX low -> DATA with counter cleared; synced RX high -> IDLE (false start, no flags change).
REQ-018 In DATA, a bit SHALL be sampled each time the counter reaches BAUD_DIV-1 (mid-bit), then the counter clears; the bit counter increments per sample.
REQ-019 Bits SHALL shift into an internal register LSB-first; after DATA_BITS samples -> PARITY (macro) or STOP.
REQ-020 In PARITY, one mid-bit sample SHALL be checked against the data XOR (inverted if PARITY_ODD = 1); the result is held for STOP.
REQ-021 In STOP, one mid-bit sample SHALL be taken, then the FSM returns to IDLE on the next cycle.
REQ-022 At the STOP sample with rdy = 0: rx_data <= shift register, rdy <= 1, frm_err <= ~stop_bit, par_err <= parity result.
REQ-023 At the STOP sample with rdy = 1 and no clr_rdy in the same cycle: rx_data, frm_err and par_err SHALL be kept, and ovr_err <= 1.
REQ-024 clr_rdy SHALL clear rdy, frm_err, par_err and ovr_err on the next edge; clr_rdy in IDLE with rdy = 0 is a no-op.
REQ-025 clr_rdy coincident with the STOP sample: the new frame SHALL be loaded (REQ-022), rdy stays 1, and ovr_err is not set.
REQ-026 A frame with a framing error SHALL still be delivered; re-arming requires a fresh high-to-low edge, so a held-low break produces exactly one frame.
REQ-027 Falling edges outside IDLE SHALL be ignored.
REQ-028 Without parity, rdy SHALL rise between 9.5*BAUD_DIV and 9.5*BAUD_DIV+5 clk cycles after the RX falling edge (DATA_BITS = 8); with parity, add BAUD_DIV.

Reset
REQ-029 On rst_n low: FSM -> IDLE; counters, shift register and rx_data cleared to 0; rdy, frm_err, par_err and ovr_err cleared to 0; synchroniser flops set to 1 (idle line).
REQ-030 Reset mid-frame SHALL abandon the frame without asserting rdy; reception resumes on the first falling edge after release.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: the PARITY state and checker are present, and each frame is start + DATA_BITS + parity + stop.
REQ-032 UART_RX_PARITY_EN undefined: there is no PARITY state, each frame is start + DATA_BITS + stop, and par_err is a constant 0.

Verification
REQ-033 Defaults, no macro; send 0xA5 with a good stop bit -> rx_data = 0xA5, rdy = 1 within the REQ-028 window, all error flags 0.
REQ-034 A 200-cycle low glitch on RX -> FSM returns to IDLE, rdy stays 0, and a following 0x3C is received correctly.
REQ-035 Send 0x55 with the stop bit forced low -> rdy = 1, frm_err = 1, rx_data = 0x55; after clr_rdy, all flags are 0.
REQ-036 Send 0x11 then 0x22 without clr_rdy -> rx_data = 0x11, ovr_err = 1; repeat with clr_rdy on the 0x22 STOP-sample cycle -> rx_data = 0x22, ovr_err = 0.
REQ-037 Macro defined, PARITY_ODD = 0; 0x07 with parity bit 1 -> par_err = 0; 0x07 with parity bit 0 -> par_err = 1.
REQ-038 DATA_BITS = 5, BAUD_DIV = 16; send 0x1B, then assert rst_n low mid-frame -> first rx_data = 0x1B; after reset, rdy = 0 and the next frame is received correctly.
